// File: rtl/sys_ctrl_gen2.sv
// UART command controller: decodes register write/read/burst-read and ALU commands, drives the regfile, ALU and TX FIFO.
// Optional build macro SYS_CTRL_TIMEOUT_EN adds an idle-frame timeout that aborts partial commands.
module sys_ctrl_gen2 #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned RES_BYTES      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [DATA_WIDTH-1:0]           UART_RX_DATA,
  input  logic                            UART_RX_Valid,
  input  logic                            FIFO_FULL,
  output logic [DATA_WIDTH-1:0]           FIFO_WR_DATA,
  output logic                            FIFO_WR_INC,
  input  logic [RES_BYTES*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                            ALU_OUT_Valid,
  output logic                            ALU_EN,
  output logic [3:0]                      ALU_FUN,
  output logic                            CLKG_EN,
  output logic                            CLKDIV_EN,
  input  logic [DATA_WIDTH-1:0]           Rd_Reg,
  input  logic                            Rd_Reg_Valid,
  output logic [DATA_WIDTH-1:0]           Wr_Reg,
  output logic [ADDR_WIDTH-1:0]           Addr,
  output logic                            RdEn,
  output logic                            WrEn,
  output logic                            CMD_ERR,
  output logic                            BUSY
);

  localparam int unsigned RES_W = RES_BYTES * DATA_WIDTH;
  localparam int unsigned IDX_W = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_BR  = DATA_WIDTH'(8'hBE);
  localparam logic [DATA_WIDTH-1:0] CMD_OP  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_NOP = DATA_WIDTH'(8'hDD);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] WR_ADDR  = 4'd1;
  localparam logic [3:0] WR_DATA  = 4'd2;
  localparam logic [3:0] RD_ADDR  = 4'd3;
  localparam logic [3:0] BR_ADDR  = 4'd4;
  localparam logic [3:0] BR_CNT   = 4'd5;
  localparam logic [3:0] RD_WAIT  = 4'd6;
  localparam logic [3:0] RD_PUSH  = 4'd7;
  localparam logic [3:0] RD_NEXT  = 4'd8;
  localparam logic [3:0] OP_A     = 4'd9;
  localparam logic [3:0] OP_B     = 4'd10;
  localparam logic [3:0] ALU_FN   = 4'd11;
  localparam logic [3:0] ALU_WAIT = 4'd12;
  localparam logic [3:0] ALU_SEND = 4'd13;

  if (RES_BYTES < 1 || RES_BYTES > 4) begin : g_bad_res_bytes
    $error("sys_ctrl_gen2: RES_BYTES must be 1..4");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("sys_ctrl_gen2: TIMEOUT_CYCLES must be at least 2");
  end

  logic [3:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [RES_W-1:0]      res_q, res_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  err_q, err_d;

`ifdef SYS_CTRL_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q;
  logic             timed_c;
  logic             tmo_hit_c;

  // Only states that sit waiting on the next UART byte can time out.
  always_comb begin
    timed_c = state_q inside {WR_ADDR, WR_DATA, RD_ADDR, BR_ADDR, BR_CNT, OP_A, OP_B, ALU_FN};
  end

  assign tmo_hit_c = timed_c && !UART_RX_Valid && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tmo_q <= '0;
    end else if (!timed_c || UART_RX_Valid || (state_d != state_q)) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      hold_q  <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      hold_q  <= hold_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Next state, datapath updates and same-cycle bus strobes.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    hold_d       = hold_q;
    res_d        = res_q;
    idx_d        = idx_q;
    err_d        = 1'b0;
    FIFO_WR_DATA = '0;
    FIFO_WR_INC  = 1'b0;
    ALU_EN       = 1'b0;
    ALU_FUN      = 4'd0;
    CLKG_EN      = 1'b0;
    Wr_Reg       = '0;
    Addr         = '0;
    RdEn         = 1'b0;
    WrEn         = 1'b0;

    case (state_q)
      IDLE: begin
        if (UART_RX_Valid) begin
          case (UART_RX_DATA)
            CMD_WR:  state_d = WR_ADDR;
            CMD_RD:  state_d = RD_ADDR;
            CMD_BR:  state_d = BR_ADDR;
            CMD_OP:  state_d = OP_A;
            CMD_NOP: state_d = ALU_FN;
            default: err_d   = 1'b1;
          endcase
        end
      end
      WR_ADDR: begin
        if (UART_RX_Valid) begin
          addr_d  = UART_RX_DATA[ADDR_WIDTH-1:0];
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (UART_RX_Valid) begin
          WrEn    = 1'b1;
          Addr    = addr_q;
          Wr_Reg  = UART_RX_DATA;
          state_d = IDLE;
        end
      end
      RD_ADDR: begin
        if (UART_RX_Valid) begin
          RdEn    = 1'b1;
          Addr    = UART_RX_DATA[ADDR_WIDTH-1:0];
          addr_d  = UART_RX_DATA[ADDR_WIDTH-1:0];
          rem_d   = '0;
          state_d = RD_WAIT;
        end
      end
      BR_ADDR: begin
        if (UART_RX_Valid) begin
          addr_d  = UART_RX_DATA[ADDR_WIDTH-1:0];
          state_d = BR_CNT;
        end
      end
      BR_CNT: begin
        if (UART_RX_Valid) begin
          if (UART_RX_DATA == '0) begin
            state_d = IDLE;
          end else begin
            RdEn    = 1'b1;
            Addr    = addr_q;
            rem_d   = UART_RX_DATA - DATA_WIDTH'(1);
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (Rd_Reg_Valid) begin
          hold_d  = Rd_Reg;
          state_d = RD_PUSH;
        end
      end
      RD_PUSH: begin
        if (!FIFO_FULL) begin
          FIFO_WR_INC  = 1'b1;
          FIFO_WR_DATA = hold_q;
          state_d      = (rem_q == '0) ? IDLE : RD_NEXT;
        end
      end
      RD_NEXT: begin
        RdEn    = 1'b1;
        Addr    = addr_q + ADDR_WIDTH'(1);
        addr_d  = addr_q + ADDR_WIDTH'(1);
        rem_d   = rem_q - DATA_WIDTH'(1);
        state_d = RD_WAIT;
      end
      OP_A: begin
        if (UART_RX_Valid) begin
          WrEn    = 1'b1;
          Addr    = ADDR_WIDTH'(0);
          Wr_Reg  = UART_RX_DATA;
          state_d = OP_B;
        end
      end
      OP_B: begin
        if (UART_RX_Valid) begin
          WrEn    = 1'b1;
          Addr    = ADDR_WIDTH'(1);
          Wr_Reg  = UART_RX_DATA;
          state_d = ALU_FN;
        end
      end
      ALU_FN: begin
        CLKG_EN = 1'b1;
        if (UART_RX_Valid) begin
          ALU_EN  = 1'b1;
          ALU_FUN = UART_RX_DATA[3:0];
          state_d = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        CLKG_EN = 1'b1;
        if (ALU_OUT_Valid) begin
          res_d   = ALU_OUT;
          idx_d   = '0;
          state_d = ALU_SEND;
        end
      end
      ALU_SEND: begin
        CLKG_EN = 1'b1;
        // Result is shifted down one byte per push so the LSB byte is always at the bottom.
        if (!FIFO_FULL) begin
          FIFO_WR_INC  = 1'b1;
          FIFO_WR_DATA = res_q[DATA_WIDTH-1:0];
          res_d        = res_q >> DATA_WIDTH;
          if (idx_q == IDX_W'(RES_BYTES - 1)) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef SYS_CTRL_TIMEOUT_EN
    if (tmo_hit_c) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
`endif
  end

  assign CMD_ERR   = err_q;
  assign BUSY      = (state_q != IDLE);
  assign CLKDIV_EN = 1'b1;

endmodule

// File: tb/tb_sys_ctrl_gen2.sv
// Directed self-checking bench for sys_ctrl_gen2; timeout scenario selected by SYS_CTRL_TIMEOUT_EN.
module tb_sys_ctrl_gen2;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  UART_RX_DATA;
  logic        UART_RX_Valid;
  logic        FIFO_FULL;
  logic [7:0]  FIFO_WR_DATA;
  logic        FIFO_WR_INC;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_Valid;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic        CLKG_EN;
  logic        CLKDIV_EN;
  logic [7:0]  Rd_Reg;
  logic        Rd_Reg_Valid;
  logic [7:0]  Wr_Reg;
  logic [3:0]  Addr;
  logic        RdEn;
  logic        WrEn;
  logic        CMD_ERR;
  logic        BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] wr_q[$];
  logic [3:0]  rd_q[$];
  logic [7:0]  push_q[$];
  logic [3:0]  alu_q[$];
  int          err_cnt  = 0;
  int          clkg_cnt = 0;

  sys_ctrl_gen2 #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .RES_BYTES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK), .RST(RST),
    .UART_RX_DATA(UART_RX_DATA), .UART_RX_Valid(UART_RX_Valid),
    .FIFO_FULL(FIFO_FULL), .FIFO_WR_DATA(FIFO_WR_DATA), .FIFO_WR_INC(FIFO_WR_INC),
    .ALU_OUT(ALU_OUT), .ALU_OUT_Valid(ALU_OUT_Valid), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .CLKG_EN(CLKG_EN), .CLKDIV_EN(CLKDIV_EN),
    .Rd_Reg(Rd_Reg), .Rd_Reg_Valid(Rd_Reg_Valid), .Wr_Reg(Wr_Reg), .Addr(Addr),
    .RdEn(RdEn), .WrEn(WrEn), .CMD_ERR(CMD_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Event log sampled mid-cycle, away from the active edge.
  always @(negedge CLK) begin
    if (WrEn)        wr_q.push_back({Addr, Wr_Reg});
    if (RdEn)        rd_q.push_back(Addr);
    if (FIFO_WR_INC) push_q.push_back(FIFO_WR_DATA);
    if (ALU_EN)      alu_q.push_back(ALU_FUN);
    if (CMD_ERR)     err_cnt++;
    if (CLKG_EN)     clkg_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    UART_RX_DATA  = b;
    UART_RX_Valid = 1'b1;
    tick(1);
    UART_RX_Valid = 1'b0;
  endtask

  task automatic rd_respond(input logic [7:0] v);
    Rd_Reg       = v;
    Rd_Reg_Valid = 1'b1;
    tick(1);
    Rd_Reg_Valid = 1'b0;
    tick(2);
  endtask

  task automatic test_reset;
    RST = 1'b0;
    tick(2);
    n_cmp++;
    if ({WrEn, RdEn, FIFO_WR_INC, ALU_EN, CLKG_EN, CMD_ERR, BUSY} !== 7'b0) begin
      $display("FAIL reset_ctrl: got %b want 0000000", {WrEn, RdEn, FIFO_WR_INC, ALU_EN, CLKG_EN, CMD_ERR, BUSY});
      n_bad++;
    end
    n_cmp++;
    if ({Addr, Wr_Reg, FIFO_WR_DATA, ALU_FUN} !== 24'h0) begin
      $display("FAIL reset_data: got %h want 000000", {Addr, Wr_Reg, FIFO_WR_DATA, ALU_FUN});
      n_bad++;
    end
    n_cmp++;
    if (CLKDIV_EN !== 1'b1) begin
      $display("FAIL reset_clkdiv: got %b want 1", CLKDIV_EN);
      n_bad++;
    end
    RST = 1'b1;
    tick(2);
  endtask

  task automatic test_write;
    int b = wr_q.size();
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    tick(2);
    n_cmp++;
    if (wr_q.size() - b !== 1) begin
      $display("FAIL write_count: got %0d want 1", wr_q.size() - b);
      n_bad++;
    end else begin
      n_cmp++;
      if (wr_q[b] !== 12'h53C) begin
        $display("FAIL write_addr_data: got %h want 53c", wr_q[b]);
        n_bad++;
      end
    end
    n_cmp++;
    if (BUSY !== 1'b0) begin
      $display("FAIL write_busy: got %b want 0", BUSY);
      n_bad++;
    end
  endtask

  task automatic test_burst_read;
    int br = rd_q.size();
    int bp = push_q.size();
    logic [3:0] ea[3] = '{4'hE, 4'hF, 4'h0};
    logic [7:0] ed[3] = '{8'h11, 8'h22, 8'h33};
    send_byte(8'hBE); send_byte(8'h0E); send_byte(8'h03);
    rd_respond(8'h11); rd_respond(8'h22); rd_respond(8'h33);
    tick(1);
    n_cmp++;
    if (rd_q.size() - br !== 3 || push_q.size() - bp !== 3) begin
      $display("FAIL burst_counts: got rd=%0d push=%0d want 3/3", rd_q.size() - br, push_q.size() - bp);
      n_bad++;
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (rd_q[br+i] !== ea[i] || push_q[bp+i] !== ed[i]) begin
          $display("FAIL burst_item%0d: got addr=%h data=%h want %h/%h", i, rd_q[br+i], push_q[bp+i], ea[i], ed[i]);
          n_bad++;
        end
      end
    end
    n_cmp++;
    if (BUSY !== 1'b0) begin
      $display("FAIL burst_busy: got %b want 0", BUSY);
      n_bad++;
    end
  endtask

  task automatic test_burst_zero;
    int br = rd_q.size();
    send_byte(8'hBE); send_byte(8'h04); send_byte(8'h00);
    tick(3);
    n_cmp++;
    if (rd_q.size() - br !== 0 || BUSY !== 1'b0) begin
      $display("FAIL burst_zero: got reads=%0d busy=%b want 0/0", rd_q.size() - br, BUSY);
      n_bad++;
    end
  endtask

  task automatic test_alu;
    int bw = wr_q.size();
    int bp = push_q.size();
    int ba = alu_q.size();
    send_byte(8'hCC); send_byte(8'h07); send_byte(8'h03);
    clkg_cnt = clkg_cnt;
    begin
      int c0 = clkg_cnt;
      send_byte(8'h00);
      tick(2);
      ALU_OUT       = 16'h000A;
      ALU_OUT_Valid = 1'b1;
      tick(1);
      ALU_OUT_Valid = 1'b0;
      tick(4);
      n_cmp++;
      if (clkg_cnt - c0 !== 6) begin
        $display("FAIL alu_clkg_cycles: got %0d want 6", clkg_cnt - c0);
        n_bad++;
      end
    end
    n_cmp++;
    if (wr_q.size() - bw !== 2 || wr_q[bw] !== 12'h007 || wr_q[bw+1] !== 12'h103) begin
      $display("FAIL alu_operand_writes: got n=%0d", wr_q.size() - bw);
      n_bad++;
    end
    n_cmp++;
    if (alu_q.size() - ba !== 1 || alu_q[ba] !== 4'h0) begin
      $display("FAIL alu_en_fun: got n=%0d want 1 with fun 0", alu_q.size() - ba);
      n_bad++;
    end
    n_cmp++;
    if (push_q.size() - bp !== 2 || push_q[bp] !== 8'h0A || push_q[bp+1] !== 8'h00) begin
      $display("FAIL alu_result_bytes: got n=%0d want 0a,00", push_q.size() - bp);
      n_bad++;
    end
    n_cmp++;
    if (BUSY !== 1'b0 || CLKG_EN !== 1'b0) begin
      $display("FAIL alu_end_idle: got busy=%b clkg=%b want 0/0", BUSY, CLKG_EN);
      n_bad++;
    end
  endtask

  task automatic test_fifo_full;
    int bp = push_q.size();
    send_byte(8'hBB); send_byte(8'h09);
    FIFO_FULL = 1'b1;
    rd_respond(8'h5A);
    tick(2);
    n_cmp++;
    if (push_q.size() - bp !== 0 || BUSY !== 1'b1) begin
      $display("FAIL full_stall: got pushes=%0d busy=%b want 0/1", push_q.size() - bp, BUSY);
      n_bad++;
    end
    FIFO_FULL = 1'b0;
    tick(3);
    n_cmp++;
    if (push_q.size() - bp !== 1 || push_q[bp] !== 8'h5A) begin
      $display("FAIL full_release_push: got n=%0d want one push of 5a", push_q.size() - bp);
      n_bad++;
    end
    n_cmp++;
    if (rd_q[rd_q.size()-1] !== 4'h9 || BUSY !== 1'b0) begin
      $display("FAIL single_read_addr: got %h busy=%b want 9/0", rd_q[rd_q.size()-1], BUSY);
      n_bad++;
    end
  endtask

  task automatic test_cmd_err;
    int be = err_cnt;
    send_byte(8'h55);
    n_cmp++;
    if (CMD_ERR !== 1'b1 || BUSY !== 1'b0) begin
      $display("FAIL cmd_err_pulse: got err=%b busy=%b want 1/0", CMD_ERR, BUSY);
      n_bad++;
    end
    tick(3);
    n_cmp++;
    if (err_cnt - be !== 1) begin
      $display("FAIL cmd_err_width: got %0d cycles want 1", err_cnt - be);
      n_bad++;
    end
  endtask

  task automatic test_timeout;
    int bw = wr_q.size();
    int hit = 0;
    send_byte(8'hAA); send_byte(8'h05);
`ifdef SYS_CTRL_TIMEOUT_EN
    for (int i = 1; i <= 40 && hit == 0; i++) begin
      tick(1);
      if (CMD_ERR === 1'b1) hit = i;
    end
    n_cmp++;
    if (hit !== 16 || BUSY !== 1'b0) begin
      $display("FAIL timeout_abort: got cycle=%0d busy=%b want 16/0", hit, BUSY);
      n_bad++;
    end
    n_cmp++;
    if (wr_q.size() - bw !== 0) begin
      $display("FAIL timeout_no_write: got %0d writes want 0", wr_q.size() - bw);
      n_bad++;
    end
`else
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if (CMD_ERR === 1'b1 && hit == 0) hit = i;
    end
    n_cmp++;
    if (hit !== 0 || BUSY !== 1'b1) begin
      $display("FAIL no_timeout_wait: got err_cycle=%0d busy=%b want 0/1", hit, BUSY);
      n_bad++;
    end
    send_byte(8'h3C);
    tick(1);
    n_cmp++;
    if (wr_q.size() - bw !== 1 || wr_q[bw] !== 12'h53C) begin
      $display("FAIL no_timeout_write: got n=%0d want one write 53c", wr_q.size() - bw);
      n_bad++;
    end
`endif
  endtask

  task automatic test_reset_mid_frame;
    int bw = wr_q.size();
    int br = rd_q.size();
    int bp = push_q.size();
    send_byte(8'hAA); send_byte(8'h05);
    RST = 1'b0;
    #3;
    n_cmp++;
    if (BUSY !== 1'b0 || CLKDIV_EN !== 1'b1) begin
      $display("FAIL midreset_async: got busy=%b clkdiv=%b want 0/1", BUSY, CLKDIV_EN);
      n_bad++;
    end
    tick(2);
    RST = 1'b1;
    tick(1);
    send_byte(8'h3C);
    tick(3);
    n_cmp++;
    if (wr_q.size() - bw !== 0 || rd_q.size() - br !== 0 || push_q.size() - bp !== 0 || BUSY !== 1'b0) begin
      $display("FAIL midreset_discard: got wr=%0d rd=%0d push=%0d busy=%b want 0/0/0/0",
               wr_q.size() - bw, rd_q.size() - br, push_q.size() - bp, BUSY);
      n_bad++;
    end
  endtask

  task automatic test_back_to_back;
    int bw = wr_q.size();
    int bp = push_q.size();
    int ba = alu_q.size();
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h77);
    send_byte(8'hDD); send_byte(8'h05);
    ALU_OUT       = 16'h1234;
    ALU_OUT_Valid = 1'b1;
    tick(1);
    ALU_OUT_Valid = 1'b0;
    tick(3);
    n_cmp++;
    if (wr_q.size() - bw !== 1 || wr_q[bw] !== 12'h277) begin
      $display("FAIL b2b_write: got n=%0d want one write 277", wr_q.size() - bw);
      n_bad++;
    end
    n_cmp++;
    if (alu_q.size() - ba !== 1 || alu_q[ba] !== 4'h5) begin
      $display("FAIL b2b_alu_fun: got n=%0d want fun 5", alu_q.size() - ba);
      n_bad++;
    end
    n_cmp++;
    if (push_q.size() - bp !== 2 || push_q[bp] !== 8'h34 || push_q[bp+1] !== 8'h12) begin
      $display("FAIL b2b_result: got n=%0d want 34,12", push_q.size() - bp);
      n_bad++;
    end
  endtask

  initial begin
    RST           = 1'b0;
    UART_RX_DATA  = '0;
    UART_RX_Valid = 1'b0;
    FIFO_FULL     = 1'b0;
    ALU_OUT       = '0;
    ALU_OUT_Valid = 1'b0;
    Rd_Reg        = '0;
    Rd_Reg_Valid  = 1'b0;
    #2;
    test_reset();
    test_write();
    test_burst_read();
    test_burst_zero();
    test_alu();
    test_fifo_full();
    test_cmd_err();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sys_ctrl_gen2.md
SYS_CTRL_GEN2 -- requirements
Module: sys_ctrl_gen2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: UART, FIFO and register-file data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: register-file address width.
REQ-003 SHALL have parameter RES_BYTES, default 2: ALU result width in DATA_WIDTH bytes (range 1..4).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024: number of idle cycles before a frame is aborted.
REQ-005 SHALL have ports, in this order:
- CLK in 1: clock.
- RST in 1: reset, asynchronous, active-low.
- UART_RX_DATA in DATA_WIDTH; UART_RX_Valid in 1: synchronized receive byte and its one-cycle strobe.
- FIFO_FULL in 1; FIFO_WR_DATA out DATA_WIDTH; FIFO_WR_INC out 1: transmit FIFO push.
- ALU_OUT in RES_BYTES*DATA_WIDTH; ALU_OUT_Valid in 1; ALU_EN out 1; ALU_FUN out 4.
- CLKG_EN out 1: ALU clock gate enable; CLKDIV_EN out 1.
- Rd_Reg in DATA_WIDTH; Rd_Reg_Valid in 1; Wr_Reg out DATA_WIDTH; Addr out ADDR_WIDTH; RdEn out 1; WrEn out 1.
- CMD_ERR out 1: one-cycle error pulse.
- BUSY out 1: high whenever the state is not IDLE.

Function
REQ-006 SHALL decode the command byte in IDLE on UART_RX_Valid as follows:
- 0xAA: write.
- 0xBB: single read.
- 0xBE: burst read.
- 0xCC: ALU operation with operands.
- 0xDD: ALU operation without operands.
- Any other value: stay in IDLE and pulse CMD_ERR for one cycle.
REQ-007 SHALL use the states IDLE, WR_ADDR, WR_DATA, RD_ADDR, BR_ADDR, BR_CNT, RD_WAIT, RD_PUSH, RD_NEXT, OP_A, OP_B, ALU_FN, ALU_WAIT, ALU_SEND.
REQ-008 In every state, outputs not explicitly driven SHALL be 0; the exception is CLKDIV_EN, which SHALL be constant 1.
REQ-009 Write command (0xAA): WR_ADDR SHALL latch UART_RX_DATA[ADDR_WIDTH-1:0] on valid. In WR_DATA, on valid, WrEn=1, Addr=latched address and Wr_Reg=UART_RX_DATA in that same cycle, then the FSM SHALL go to IDLE.
REQ-010 Single read (0xBB): in RD_ADDR, on valid, RdEn=1 and Addr=UART_RX_DATA[ADDR_WIDTH-1:0] in that same cycle; the address and remaining count=0 SHALL be latched; next state RD_WAIT.
REQ-011 Burst read (0xBE): BR_ADDR SHALL latch the start address; BR_CNT SHALL latch count N.
- N=0: return to IDLE with no read.
- N>0: RdEn=1 with Addr=start in the BR_CNT valid cycle, remaining=N-1, next state RD_WAIT.
REQ-012 RD_WAIT SHALL capture Rd_Reg into a hold register on Rd_Reg_Valid and go to RD_PUSH; Rd_Reg_Valid in any other state SHALL be ignored.
REQ-013 RD_PUSH SHALL wait while FIFO_FULL=1. When FIFO_FULL=0 it SHALL drive FIFO_WR_INC=1 with FIFO_WR_DATA=hold for exactly one cycle, then go to IDLE if remaining=0, else to RD_NEXT.
REQ-014 RD_NEXT SHALL drive RdEn=1 with Addr=address+1, wrapping modulo 2^ADDR_WIDTH; it SHALL update the address, decrement remaining, and go to RD_WAIT.
REQ-015 ALU with operands (0xCC): in OP_A, on valid, WrEn=1, Addr=0, Wr_Reg=data. In OP_B, on valid, WrEn=1, Addr=1, Wr_Reg=data. Next state ALU_FN.
REQ-016 ALU without operands (0xDD) SHALL go directly to ALU_FN.
REQ-017 ALU_FN, on valid, SHALL drive ALU_EN=1 and ALU_FUN=UART_RX_DATA[3:0] in that cycle, then go to ALU_WAIT.
REQ-018 ALU_WAIT SHALL latch ALU_OUT on ALU_OUT_Valid, clear the byte index, and go to ALU_SEND.
REQ-019 ALU_SEND SHALL push byte[index] (LSB first) in each cycle with FIFO_WR_INC=1 and FIFO_FULL=0, and stall while FIFO_FULL=1. After byte RES_BYTES-1 it SHALL go to IDLE.
REQ-020 CLKG_EN SHALL be 1 in ALU_FN, ALU_WAIT and ALU_SEND, and 0 in all other states.
REQ-021 UART_RX_Valid SHALL be ignored in RD_WAIT, RD_PUSH, RD_NEXT, ALU_WAIT and ALU_SEND.

Reset
REQ-022 On RST=0 the block SHALL enter IDLE asynchronously and clear all latched address, count, hold, ALU result, index and timeout registers.
REQ-023 While in reset, all outputs SHALL be 0 except CLKDIV_EN=1.
REQ-024 A reset asserted mid-frame SHALL discard that frame; no WrEn, RdEn or FIFO_WR_INC SHALL follow release until a new command arrives.

Configuration
REQ-025 With SYS_CTRL_TIMEOUT_EN defined, a counter SHALL run in WR_ADDR, WR_DATA, RD_ADDR, BR_ADDR, BR_CNT, OP_A, OP_B and ALU_FN.
- It SHALL clear on state entry and on every UART_RX_Valid.
- On reaching TIMEOUT_CYCLES-1 the FSM SHALL go to IDLE and pulse CMD_ERR.
REQ-026 Without SYS_CTRL_TIMEOUT_EN, no counter SHALL exist and those states SHALL wait indefinitely.

Verification
REQ-027 Bytes AA,05,3C -> one cycle with WrEn=1, Addr=5, Wr_Reg=0x3C; BUSY low afterwards.
REQ-028 Bytes BE,0E,03, Rd_Reg returning 11,22,33 -> RdEn at addresses E,F,0 (wrap); FIFO receives 11,22,33 in order.
REQ-029 Bytes CC,07,03,00 with ALU_OUT=0x000A -> writes to Addr 0 and Addr 1, ALU_EN with ALU_FUN=0; FIFO receives 0A then 00; CLKG_EN high from ALU_FN through the last push.
REQ-030 Single read with FIFO_FULL=1 held 5 cycles after Rd_Reg_Valid -> no push while full; exactly one push on the first not-full cycle.
REQ-031 Byte 0x55 in IDLE -> CMD_ERR one-cycle pulse and state stays IDLE.
REQ-032 With SYS_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16, bytes AA,05 followed by silence -> CMD_ERR pulse 16 cycles later and return to IDLE; no WrEn occurs.
